// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_lsu
// Description : Data memory with a built-in load/store unit for the RISC-V
//               core. Accepts one request at a time over a valid/ready
//               handshake, optionally idles for WAIT_STATES cycles, then
//               performs the access and returns a one-cycle response pulse.
//               Supports LB/LBU/LH/LHU/LW loads and SB/SH/SW stores with
//               lane-masked writes, sign/zero extension and fault detection
//               (misaligned, illegal funct3, load-only funct3 used as store).
//
// Parameters  : DEPTH_WORDS - number of 32-bit words (power of two, >= 4)
//               WAIT_STATES - extra cycles between accept and access (0..15)
//
// Ports       : clk        in   1   system clock, rising edge
//               rst_n      in   1   asynchronous active-low reset
//               req_valid  in   1   request present
//               req_ready  out  1   block can accept a request
//               req_we     in   1   1 = store, 0 = load
//               req_funct3 in   3   RISC-V funct3 (size and sign)
//               req_addr   in   32  byte address
//               req_wdata  in   32  right-aligned store data
//               rsp_valid  out  1   one-cycle response pulse
//               rsp_rdata  out  32  formatted load data (0 for stores/faults)
//               rsp_err    out  1   access faulted, qualified by rsp_valid
//
// Build macro : DMEM_BOUNDS_CHECK_EN - when defined, any address bit set above
//               the memory's byte range faults. When undefined, upper address
//               bits are ignored and accesses wrap modulo DEPTH_WORDS*4.
//
// Revision    : 1.0 - initial release
// ============================================================================

module data_memory_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Number of captured address bits: the full address is only needed when the
  // bounds check has to look at the bits above the memory's byte range.
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam int ADDR_KEEP = 32;
`else
  localparam int ADDR_KEEP = AW + 2;
`endif

  localparam logic [3:0] C_WAIT = WAIT_STATES[3:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [ADDR_KEEP-1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [31:0]            mem [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Datapath decode (operates on the captured request)
  // --------------------------------------------------------------------------
  logic [AW-1:0]  word_idx;
  logic [1:0]     lane;
  logic [31:0]    rd_word;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    load_data;
  logic           fault;
  logic           bad_funct3;
  logic           misaligned;
  logic           out_of_range;
  logic [3:0]     byte_en;
  logic [31:0]    wdata_lanes;
  logic           mem_we;

`ifndef DMEM_BOUNDS_CHECK_EN
  // Upper address bits are deliberately ignored (address wrap); fold them
  // into a sink so they are visibly consumed.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];
`endif

  assign word_idx = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign rd_word  = mem[word_idx];

  always_comb begin
    rd_byte = 8'h00;
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h00_0000, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0000, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // funct3 011/110/111 never name a valid access; 100/101 exist only as loads.
  always_comb begin
    bad_funct3 = 1'b0;
    case (funct3_q)
      3'b011, 3'b110, 3'b111: bad_funct3 = 1'b1;
      3'b100, 3'b101:         bad_funct3 = we_q;
      default:                bad_funct3 = 1'b0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = |addr_q[31:AW+2];
`else
  assign out_of_range = 1'b0;
`endif

  assign fault = bad_funct3 | misaligned | out_of_range;

  // Store data is replicated across lanes so the byte enables alone pick
  // which copy lands in memory.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata_q;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = wdata_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and register updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[ADDR_KEEP-1:0];
          wdata_d  = req_wdata;
          if (C_WAIT == 4'd0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = C_WAIT;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        mem_we      = we_q & ~fault;
        rsp_err_d   = fault;
        rsp_rdata_d = (we_q | fault) ? 32'h0000_0000 : load_data;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory array is not reset. An asserted reset forces the FSM out of
  // ST_ACCESS immediately, so a dropped request can never write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_lsu
// Description : Self-checking bench for data_memory_lsu. Two instances are
//               exercised: one with no wait states and one with three. A
//               byte-addressed reference memory predicts every response; a
//               single compare process checks handshake, latency and response
//               on every falling edge. Directed literal expectations pin the
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_data_memory_lsu;

  localparam int DEPTH     = 64;
  localparam int MEM_BYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int n_checks;
  int n_errors;
  int cyc;

  // Reference model state and scoreboard
  logic [7:0]  model_mem [2][MEM_BYTES];
  logic        pending   [2];
  logic        dropping  [2];
  int          due       [2];
  logic [31:0] exp_rdata [2];
  logic        exp_err   [2];
  logic [31:0] last_rdata[2];
  logic        last_err  [2];

  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_funct3 (req_funct3[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .rsp_valid  (rsp_valid[0]),
    .rsp_rdata  (rsp_rdata[0]),
    .rsp_err    (rsp_err[0])
  );

  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_funct3 (req_funct3[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .rsp_valid  (rsp_valid[1]),
    .rsp_rdata  (rsp_rdata[1]),
    .rsp_err    (rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: byte-addressed memory, RISC-V load/store rules.
  task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic er);
    int nbytes;
    int off;
    logic [31:0] val;
    nbytes = 1 << f3[1:0];
    er = 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) er = 1'b1;
    if (we && f3[2]) er = 1'b1;
    if (nbytes == 2 && (addr % 2) != 0) er = 1'b1;
    if (nbytes == 4 && (addr % 4) != 0) er = 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (addr >= MEM_BYTES) er = 1'b1;
`endif
    off = int'(addr % MEM_BYTES);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++)
          model_mem[d][off + i] = wdata[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < nbytes; i++)
          val = val | (32'(model_mem[d][off + i]) << (8 * i));
        if (!f3[2] && nbytes < 4 && val[8*nbytes - 1])
          val = val | (32'hFFFF_FFFF << (8 * nbytes));
        rd = val;
      end
    end
  endtask

  // One compare process covering both instances every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        chk($sformatf("reset_ready%0d", d), {31'b0, req_ready[d]}, 32'd1);
        chk($sformatf("reset_rsp_valid%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
        chk($sformatf("reset_rdata%0d", d), rsp_rdata[d], 32'd0);
        chk($sformatf("reset_err%0d", d), {31'b0, rsp_err[d]}, 32'd0);
      end else if (pending[d]) begin
        chk($sformatf("busy_ready%0d", d), {31'b0, req_ready[d]}, 32'd0);
        if (cyc == due[d]) begin
          chk($sformatf("rsp_valid%0d", d), {31'b0, rsp_valid[d]}, 32'd1);
          chk($sformatf("rsp_rdata%0d", d), rsp_rdata[d], exp_rdata[d]);
          chk($sformatf("rsp_err%0d", d), {31'b0, rsp_err[d]}, {31'b0, exp_err[d]});
          last_rdata[d] = rsp_rdata[d];
          last_err[d]   = rsp_err[d];
          pending[d]    = 1'b0;
        end else if (cyc > due[d]) begin
          chk($sformatf("rsp_late%0d", d), 32'(cyc), 32'(due[d]));
          pending[d] = 1'b0;
        end else begin
          chk($sformatf("early_rsp%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
        end
      end else if (!dropping[d]) begin
        chk($sformatf("idle_ready%0d", d), {31'b0, req_ready[d]}, 32'd1);
        chk($sformatf("idle_rsp_valid%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
      end
    end
  end

  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic [31:0] erd;
    logic eer;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      chk($sformatf("ready_timeout%0d", d), 32'd0, 32'd1);
      return;
    end
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    model_access(d, we, f3, addr, wdata, erd, eer);
    exp_rdata[d] = erd;
    exp_err[d]   = eer;
    due[d]       = cyc + wait_of(d) + 1;
    pending[d]   = 1'b1;
    n = 0;
    while (pending[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (pending[d]) begin
      chk($sformatf("rsp_timeout%0d", d), 32'd0, 32'd1);
      pending[d] = 1'b0;
    end
  endtask

  task automatic expect_rsp(input string name, input int d,
                            input logic [31:0] rd, input logic er);
    chk({name, "_rdata"}, last_rdata[d], rd);
    chk({name, "_err"}, {31'b0, last_err[d]}, {31'b0, er});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b0;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'b000;
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
      pending[d]    = 1'b0;
      dropping[d]   = 1'b0;
      due[d]        = 0;
      last_rdata[d] = 32'h0;
      last_err[d]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Word store and readback
    do_req(0, 1'b1, 3'b010, 32'h10, 32'h8000_00F0);
    expect_rsp("sw_10", 0, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
    expect_rsp("lw_10", 0, 32'h8000_00F0, 1'b0);

    // Byte store into lane 3, then byte/word loads
    do_req(0, 1'b1, 3'b010, 32'h10, 32'h1122_3344);
    do_req(0, 1'b1, 3'b000, 32'h13, 32'hFFFF_FFAB);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
    expect_rsp("lw_after_sb", 0, 32'hAB22_3344, 1'b0);
    do_req(0, 1'b0, 3'b000, 32'h13, 32'h0);
    expect_rsp("lb_13", 0, 32'hFFFF_FFAB, 1'b0);
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0);
    expect_rsp("lbu_13", 0, 32'h0000_00AB, 1'b0);
    do_req(0, 1'b0, 3'b100, 32'h11, 32'h0);
    expect_rsp("lbu_11", 0, 32'h0000_0033, 1'b0);
    do_req(0, 1'b0, 3'b000, 32'h10, 32'h0);
    expect_rsp("lb_10", 0, 32'h0000_0044, 1'b0);
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0);
    expect_rsp("lh_12", 0, 32'hFFFF_AB22, 1'b0);

    // Upper halfword store, lower half preserved
    do_req(0, 1'b1, 3'b010, 32'h14, 32'h1234_5678);
    do_req(0, 1'b1, 3'b001, 32'h16, 32'h0000_8001);
    do_req(0, 1'b0, 3'b001, 32'h16, 32'h0);
    expect_rsp("lh_16", 0, 32'hFFFF_8001, 1'b0);
    do_req(0, 1'b0, 3'b101, 32'h16, 32'h0);
    expect_rsp("lhu_16", 0, 32'h0000_8001, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h14, 32'h0);
    expect_rsp("lw_14", 0, 32'h8001_5678, 1'b0);

    // Faults
    do_req(0, 1'b0, 3'b010, 32'h12, 32'h0);
    expect_rsp("lw_mis", 0, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b001, 32'h11, 32'h0000_FFFF);
    expect_rsp("sh_mis", 0, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b011, 32'h10, 32'h0);
    expect_rsp("ld_f3_011", 0, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
    expect_rsp("st_f3_100", 0, 32'h0, 1'b1);
    do_req(0, 1'b1, 3'b111, 32'h10, 32'hFFFF_FFFF);
    expect_rsp("st_f3_111", 0, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
    expect_rsp("lw_unchanged", 0, 32'hAB22_3344, 1'b0);

    // Address beyond the array
    do_req(0, 1'b1, 3'b010, 32'h0, 32'h0102_0304);
    do_req(0, 1'b1, 3'b010, 32'h100, 32'hCAFE_BABE);
`ifdef DMEM_BOUNDS_CHECK_EN
    expect_rsp("sw_100", 0, 32'h0, 1'b1);
    do_req(0, 1'b0, 3'b010, 32'h0, 32'h0);
    expect_rsp("lw_0", 0, 32'h0102_0304, 1'b0);
`else
    expect_rsp("sw_100", 0, 32'h0, 1'b0);
    do_req(0, 1'b0, 3'b010, 32'h0, 32'h0);
    expect_rsp("lw_0", 0, 32'hCAFE_BABE, 1'b0);
`endif

    // Wait-state instance: latency checked by the compare process
    do_req(1, 1'b1, 3'b010, 32'h4, 32'h0BAD_F00D);
    do_req(1, 1'b0, 3'b010, 32'h4, 32'h0);
    expect_rsp("ws_lw_4", 1, 32'h0BAD_F00D, 1'b0);
    do_req(1, 1'b0, 3'b101, 32'h6, 32'h0);
    expect_rsp("ws_lhu_6", 1, 32'h0000_0BAD, 1'b0);
    do_req(1, 1'b1, 3'b010, 32'h20, 32'h5555_AAAA);

    // Reset while in the wait states: request must vanish
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 32'h20;
    req_wdata[1]  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    dropping[1]  = 1'b1;
    @(negedge clk);
    chk("drop_busy_ready", {31'b0, req_ready[1]}, 32'd0);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("drop_async_ready", {31'b0, req_ready[1]}, 32'd1);
    chk("drop_async_rsp", {31'b0, rsp_valid[1]}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n[1]    = 1'b1;
    dropping[1] = 1'b0;
    repeat (6) @(negedge clk);
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0);
    expect_rsp("drop_no_write", 1, 32'h5555_AAAA, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
